led_debug_probe: RTL

Parametrised on-board debug observer for FPGA bring-up of the CPU. It generates a divided clock enable for the core and samples CHANNELS probe words, e.g. selected register-file entries. It shows one LED_WIDTH-bit slice of the selected channel on board LEDs. A debounced push-button cycles the channel, switches pick the slice and freeze the display, and a sticky flag marks that the shown value changed.

---
 rtl/led_debug_probe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/led_debug_probe.sv
// On-board debug observer: divided core clock enable, debounced channel stepping,
// switch-selected LED slice of a probe word with freeze and a sticky change flag.
module led_debug_probe #(
  parameter int DATA_WIDTH      = 32,
  parameter int CHANNELS        = 4,
  parameter int LED_WIDTH       = 16,
  parameter int CLK_DIV         = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  localparam int SLICES = DATA_WIDTH / LED_WIDTH,
  localparam int SEL_W  = (SLICES > 1) ? $clog2(SLICES) : 1,
  localparam int CH_W   = $clog2(CHANNELS)
) (
  input  logic                           sysClk,
  input  logic                           sysRes,
  input  logic [CHANNELS*DATA_WIDTH-1:0] probeIn,
  input  logic                           btnNext,
  input  logic [SEL_W-1:0]               sliceSel,
  input  logic                           swFreeze,
  output logic                           cpuClkEn,
  output logic [LED_WIDTH-1:0]           ledOut,
  output logic [CH_W-1:0]                chanSel,
  output logic                           changed
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   SLICE_LIM = (SEL_W + 1)'(SLICES);

  logic [DIV_W-1:0]     div_cnt_r;
  logic                 clk_en_r;
  logic                 btn_meta_r, btn_sync_r;
  logic                 frz_meta_r, frz_sync_r;
  logic [SEL_W-1:0]     sel_meta_r, sel_sync_r;
  logic [DB_W-1:0]      db_cnt_r;
  logic                 db_state_r;
  logic                 adv_r;
  logic [CH_W-1:0]      chan_r;
  logic [LED_WIDTH-1:0] led_r;
  logic                 changed_r;
  logic [CH_W-1:0]      last_chan_r;
  logic [SEL_W-1:0]     last_slice_r;

  logic [SEL_W-1:0]      slice_s;
  logic [DATA_WIDTH-1:0] chan_word_s;
  logic [LED_WIDTH-1:0]  slice_word_s;
  logic                  sample_s;
  logic                  db_flip_s;

  logic [DATA_WIDTH-1:0] chan_arr [CHANNELS];
  logic [LED_WIDTH-1:0]  slice_arr [SLICES];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign chan_arr[g] = probeIn[g*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar g = 0; g < SLICES; g++) begin : g_slice
    assign slice_arr[g] = chan_word_s[g*LED_WIDTH +: LED_WIDTH];
  end

  // Out-of-range slice switches fall back to slice 0; select the displayed word.
  always_comb begin
    slice_s = '0;
    if ({1'b0, sel_sync_r} < SLICE_LIM) begin
      slice_s = sel_sync_r;
    end else begin
      slice_s = '0;
    end
    chan_word_s  = chan_arr[chan_r];
    slice_word_s = slice_arr[slice_s];
    sample_s     = clk_en_r & ~frz_sync_r;
    db_flip_s    = (btn_sync_r != db_state_r) && (db_cnt_r == DB_LAST);
  end

  // Clock-enable divider.
  always_ff @(posedge sysClk) begin
    if (!sysRes) begin
      div_cnt_r <= '0;
      clk_en_r  <= 1'b0;
    end else begin
      clk_en_r  <= (div_cnt_r == DIV_LAST);
      div_cnt_r <= (div_cnt_r == DIV_LAST) ? '0 : div_cnt_r + 1'b1;
    end
  end

  // Two-flop synchronisers for the raw button and switches.
  always_ff @(posedge sysClk) begin
    if (!sysRes) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
      frz_meta_r <= 1'b0;
      frz_sync_r <= 1'b0;
      sel_meta_r <= '0;
      sel_sync_r <= '0;
    end else begin
      btn_meta_r <= btnNext;
      btn_sync_r <= btn_meta_r;
      frz_meta_r <= swFreeze;
      frz_sync_r <= frz_meta_r;
      sel_meta_r <= sliceSel;
      sel_sync_r <= sel_meta_r;
    end
  end

  // Debounce; an accepted press raises adv_r, stepping the channel one edge later.
  always_ff @(posedge sysClk) begin
    if (!sysRes) begin
      db_cnt_r   <= '0;
      db_state_r <= 1'b0;
      adv_r      <= 1'b0;
      chan_r     <= '0;
    end else begin
      if (btn_sync_r == db_state_r || db_flip_s) begin
        db_cnt_r <= '0;
      end else begin
        db_cnt_r <= db_cnt_r + 1'b1;
      end
      if (db_flip_s) begin
        db_state_r <= btn_sync_r;
      end
      adv_r <= db_flip_s & btn_sync_r;
      if (adv_r) begin
        chan_r <= (chan_r == CH_LAST) ? '0 : chan_r + 1'b1;
      end
    end
  end

  // Display sampling and sticky change flag (clear beats set).
  always_ff @(posedge sysClk) begin
    if (!sysRes) begin
      led_r        <= '0;
      changed_r    <= 1'b0;
      last_chan_r  <= '0;
      last_slice_r <= '0;
    end else begin
      if (sample_s) begin
        led_r        <= slice_word_s;
        last_chan_r  <= chan_r;
        last_slice_r <= slice_s;
      end
      if (adv_r) begin
        changed_r <= 1'b0;
      end else if (sample_s && (slice_word_s != led_r) &&
                   (chan_r == last_chan_r) && (slice_s == last_slice_r)) begin
        changed_r <= 1'b1;
      end
    end
  end

  assign cpuClkEn = clk_en_r;
  assign ledOut   = led_r;
  assign chanSel  = chan_r;
  assign changed  = changed_r;

endmodule
